pipelined_barrel_right_shifter: RTL and testbench
=================================================

# pipelined_barrel_right_shifter

Two-stage pipelined 32-bit barrel right shifter with valid/ready handshakes on both sides. It performs logical and, when compiled in, arithmetic right shifts, and is the right-shift counterpart to the existing combinational left shifter. It sits in the execute stage of the processor datapath, feeding the ALU result mux. Back-pressure from writeback stalls the pipeline without dropping or duplicating operations.

## Interface
- `RESET_DATA`, default 32'h0000_0000: value driven on `out_data` while reset is asserted and until the first result is loaded.
- `clock`: input, 1 bit. Single clock; all registers update on the rising edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `in_valid`: input, 1 bit. Operand on `in_data`/`in_shamt`/`in_arith` is valid.
- `in_ready`: output, 1 bit. Block accepts an operand this cycle.
- `in_data`: input, 32 bits. Value to shift.
- `in_shamt`: input, 5 bits. Shift amount, 0–31.
- `in_arith`: input, 1 bit. 1 selects arithmetic shift (sign fill); 0 selects logical shift (zero fill).
- `out_valid`: output, 1 bit. `out_data` holds a result.
- `out_ready`: input, 1 bit. Consumer takes the result this cycle.
- `out_data`: output, 32 bits. Shifted result.

## Operation
- Transfer rules:
  - An input transfer occurs when `in_valid && in_ready`.
  - An output transfer occurs when `out_valid && out_ready`.
- Stage 1 (S1) register holds:
  - the data after the shift-by-16 and shift-by-8 layers (controlled by `in_shamt[4]` and `in_shamt[3]`);
  - `in_shamt[2:0]`;
  - the fill bit: `in_data[31] & in_arith`;
  - a valid flag `s1_valid`.
- Stage 2 (S2 = output register) applies the 4/2/1 layers, using the registered shamt bits and the registered fill bit.
  - It loads `out_data` and `out_valid`.
- Fill rule: every vacated MSB takes the fill bit. The fill bit is captured at input, so a sign decision never depends on intermediate data.
- Advance logic:
  - `s2_take = !out_valid || out_ready`.
  - `s1_adv = s1_valid && s2_take`.
  - `in_ready = !s1_valid || s2_take`. This is combinational; it never depends on `in_valid`.
- S2 update:
  - If `s1_adv`, load the result and set `out_valid`.
  - Else, if `out_ready`, clear `out_valid` and hold `out_data`.
- S1 update:
  - If an input transfer occurs, load and set `s1_valid`.
  - Else, if `s1_adv`, clear `s1_valid`.
- Shift of 0 passes data unchanged, regardless of `in_arith`.
- Simultaneous events: an input transfer, an S1 to S2 advance and an output transfer may all occur in one cycle. Full throughput is one op per cycle when `out_ready` is held high.
- Ordering: results emerge strictly in input order. No op is lost or duplicated under any stall pattern.

## Timing
- Reset (synchronous; takes effect on the first rising edge with `reset` = 1):
  - `s1_valid` = 0, `out_valid` = 0, `out_data` = `RESET_DATA`.
  - `in_ready` reads 1 after reset.
- Reset mid-operation discards in-flight ops in both stages. No result from before reset appears afterward.
- Latency: an input accepted at edge N produces `out_valid` = 1 after edge N+1, provided S2 is free. It is therefore visible in the cycle following edge N+1.
- Stall behaviour:
  - With `out_ready` = 0 and both stages full, `in_ready` = 0.
  - `out_data` and `out_valid` are held stable until consumed.
- Wrap-around: none. Shift amounts above 31 are impossible because `in_shamt` is 5 bits wide.

## Configuration
- `RSHIFT_ARITH_EN`
  - Defined: `in_arith` is honoured as described.
  - Undefined: `in_arith` is ignored, the fill bit is constant 0, the sign-capture flop is not built, and all shifts are logical.
  - Port list is identical in both builds.

## Test plan
- Logical shift: `in_data`=32'h8000_0000, shamt=4, arith=0 → `out_data`=32'h0800_0000, `out_valid` asserted 2 edges after the input transfer.
- Arithmetic shift (macro defined): 32'h8000_0000, shamt=4, arith=1 → 32'hF800_0000. Same input with shamt=31 → 32'hFFFF_FFFF. With the macro undefined, both cases yield the logical result (32'h0800_0000 and 32'h0000_0001 respectively).
- Boundary amounts:
  - 32'h1234_5678, shamt=0 → 32'h1234_5678 for both arith settings.
  - Shamt=31 on 32'h7FFF_FFFF, arith=1 → 32'h0000_0000.
- Back-to-back stream of 8 ops with `out_ready`=1 → 8 results on 8 consecutive cycles, in order, with `in_ready` constantly 1.
- Back-pressure: hold `out_ready`=0 while streaming →
  - `in_ready` drops after 2 accepted ops;
  - `out_data` holds the first result;
  - releasing `out_ready` drains the results in order with none lost.
- Reset mid-operation: assert `reset` for one cycle with both stages full → `out_valid`=0, `out_data`=`RESET_DATA` and `in_ready`=1 on the next cycle. No stale result appears afterward.

Source files
------------

// File: rtl/pipelined_barrel_right_shifter.sv
// pipelined_barrel_right_shifter
//
// Two-stage pipelined 32-bit barrel right shifter with valid/ready handshakes on
// both sides. Stage 1 applies the shift-by-16 and shift-by-8 layers. Stage 2 is
// the output register, and it applies the 4/2/1 layers. Throughput is one op per
// cycle while out_ready stays high. Back-pressure stalls the pipeline without
// losing or duplicating ops.
//
// Build option:
//   RSHIFT_ARITH_EN  When defined, in_arith selects a sign-filled (arithmetic)
//                    shift. When undefined, in_arith is ignored and every shift
//                    is logical. The sign-capture flop is then not built.
//
// Parameters:
//   RESET_DATA  Value on out_data during reset and until the first result loads.
//
// Ports:
//   clock      Single clock. All state updates on the rising edge.
//   reset      Synchronous, active-high.
//   in_valid   Operand on in_data/in_shamt/in_arith is valid.
//   in_ready   Block accepts an operand this cycle. Does not depend on in_valid.
//   in_data    Value to shift.
//   in_shamt   Shift amount, 0-31.
//   in_arith   1: arithmetic (sign fill), 0: logical (zero fill).
//   out_valid  out_data holds a result.
//   out_ready  Consumer takes the result this cycle.
//   out_data   Shifted result.

module pipelined_barrel_right_shifter #(
  parameter logic [31:0] RESET_DATA = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [4:0]  in_shamt,
  input  logic        in_arith,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  logic        s1_valid_q;
  logic [31:0] s1_data_q;
  logic [2:0]  s1_shamt_q;
  logic [31:0] s1_data_d;
  logic        fill_in;
  logic        s1_fill;

  logic        out_valid_q;
  logic [31:0] out_data_q;
  logic [31:0] s2_data_d;

  logic        s2_take;
  logic        s1_adv;
  logic        in_fire;

  // Handshake and advance
  assign s2_take  = !out_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_take;
  assign in_ready = !s1_valid_q || s2_take;
  assign in_fire  = in_valid && in_ready;

`ifdef RSHIFT_ARITH_EN
  // The fill bit is taken from the original operand so that the sign decision
  // never depends on partially shifted data.
  logic s1_fill_q;

  assign fill_in = in_data[31] & in_arith;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_fill_q <= 1'b0;
    end else if (in_fire) begin
      s1_fill_q <= fill_in;
    end
  end

  assign s1_fill = s1_fill_q;
`else
  // Logical-only build. in_arith stays on the port list so both builds share one interface.
  logic unused_arith;

  assign unused_arith = in_arith;
  assign fill_in      = 1'b0;
  assign s1_fill      = 1'b0;
`endif

  // Stage 1 shift layers: 16 and 8
  always_comb begin
    s1_data_d = in_data;
    if (in_shamt[4]) s1_data_d = {{16{fill_in}}, s1_data_d[31:16]};
    if (in_shamt[3]) s1_data_d = {{8{fill_in}}, s1_data_d[31:8]};
  end

  // Stage 2 shift layers: 4, 2 and 1
  always_comb begin
    s2_data_d = s1_data_q;
    if (s1_shamt_q[2]) s2_data_d = {{4{s1_fill}}, s2_data_d[31:4]};
    if (s1_shamt_q[1]) s2_data_d = {{2{s1_fill}}, s2_data_d[31:2]};
    if (s1_shamt_q[0]) s2_data_d = {s1_fill, s2_data_d[31:1]};
  end

  // Stage 1 register
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= 32'h0;
      s1_shamt_q <= 3'h0;
    end else if (in_fire) begin
      s1_valid_q <= 1'b1;
      s1_data_q  <= s1_data_d;
      s1_shamt_q <= in_shamt[2:0];
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Stage 2 (output) register. Data holds when the result is consumed with nothing behind it.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= RESET_DATA;
    end else if (s1_adv) begin
      out_valid_q <= 1'b1;
      out_data_q  <= s2_data_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_pipelined_barrel_right_shifter.sv
module tb_pipelined_barrel_right_shifter;

  localparam logic [31:0] ResetData = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic        in_arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] exp_q[$];
  logic        held_flag = 1'b0;
  logic [31:0] held_val;
  int unsigned n_acc;
  int unsigned n_out;

  pipelined_barrel_right_shifter #(
    .RESET_DATA (ResetData)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_arith  (in_arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clock = ~clock;

  // Reference model: plain shift operators on the whole word
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                            input logic a);
`ifdef RSHIFT_ARITH_EN
    if (a) return 32'($signed(d) >>> s);
`endif
    return d >> s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check handshake/scoreboard, advance past the edge.
  task automatic cycle(input logic rst, input logic v, input logic [31:0] d,
                       input logic [4:0] s, input logic a, input logic ordy);
    logic did_out;
    reset = rst; in_valid = v; in_data = d; in_shamt = s; in_arith = a; out_ready = ordy;
    did_out = 1'b0;
    #1;
    if (!rst) begin
      // Two ops in flight and no consumer means nowhere to put a third.
      check("in_ready", 32'(in_ready), 32'(!(exp_q.size() == 2 && !ordy)));
      if (out_valid && out_ready) begin
        n_out++;
        did_out = 1'b1;
        if (exp_q.size() == 0) check("spurious_out", 32'(out_valid), 32'h0);
        else check("result_order", out_data, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        n_acc++;
        exp_q.push_back(ref_shift(d, s, a));
      end
      held_flag = out_valid && !out_ready;
      held_val  = out_data;
    end
    @(posedge clock);
    #1;
    if (rst) begin
      exp_q.delete();
      held_flag = 1'b0;
    end else if (held_flag) begin
      check("hold_valid", 32'(out_valid), 32'h1);
      check("hold_data", out_data, held_val);
    end
    if (did_out) did_out = 1'b0;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, ordy);
  endtask

  // Single op with a stalled consumer: checks latency and a literal expected value.
  task automatic one_op(input string tag, input logic [31:0] d, input logic [4:0] s,
                        input logic a, input logic [31:0] lit);
    cycle(1'b0, 1'b1, d, s, a, 1'b0);
    check({tag, "_valid_edge1"}, 32'(out_valid), 32'h0);
    idle(1'b0);
    check({tag, "_valid_edge2"}, 32'(out_valid), 32'h1);
    check({tag, "_data"}, out_data, lit);
    idle(1'b1);
    check({tag, "_drained"}, 32'(out_valid), 32'h0);
  endtask

  initial begin
    n_acc = 0;
    n_out = 0;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_arith = 1'b0;
    out_ready = 1'b0;

    // Reset state
    cycle(1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", out_data, ResetData);
    check("rst_in_ready", 32'(in_ready), 32'h1);

    // Directed cases
    one_op("lsr4", 32'h8000_0000, 5'd4, 1'b0, 32'h0800_0000);
`ifdef RSHIFT_ARITH_EN
    one_op("asr4", 32'h8000_0000, 5'd4, 1'b1, 32'hF800_0000);
    one_op("asr31", 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF);
`else
    one_op("asr4", 32'h8000_0000, 5'd4, 1'b1, 32'h0800_0000);
    one_op("asr31", 32'h8000_0000, 5'd31, 1'b1, 32'h0000_0001);
`endif
    one_op("sh0_l", 32'h1234_5678, 5'd0, 1'b0, 32'h1234_5678);
    one_op("sh0_a", 32'h1234_5678, 5'd0, 1'b1, 32'h1234_5678);
    one_op("asr31_pos", 32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000);
    one_op("lsr1_odd", 32'hA5A5_A5A5, 5'd1, 1'b0, 32'h52D2_D2D2);
    one_op("lsr19", 32'hFFFF_0000, 5'd19, 1'b0, 32'h0000_1FFF);

    // Back-to-back stream of 8 with out_ready held high
    n_out = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, i < 8, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b1);
      if (i >= 1 && i <= 8) check("stream_valid", 32'(out_valid), 32'h1);
    end
    check("stream_count", n_out, 32'd8);
    check("stream_empty", 32'(out_valid), 32'h0);

    // Back-pressure: only two ops fit, first result held, then drain in order
    n_acc = 0;
    n_out = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0);
    end
    check("bp_accepted", n_acc, 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'h0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    check("bp_drained", n_out, 32'd2);

    // Random traffic with random stalls
    for (int i = 0; i < 400; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    check("rand_drained", 32'(exp_q.size()), 32'h0);

    // Reset with both stages full
    cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 5'd3, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 32'hCAFE_F00D, 5'd5, 1'b0, 1'b0);
    check("pre_rst_full", 32'(in_ready), 32'h0);
    cycle(1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_out_data", out_data, ResetData);
    check("midrst_in_ready", 32'(in_ready), 32'h1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      check("no_stale", 32'(out_valid), 32'h0);
    end
    one_op("post_rst", 32'h0000_00F0, 5'd4, 1'b0, 32'h0000_000F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
